// File: rtl/pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator
//   Third-order CIC decimator: turns the 1-bit PDM microphone stream into
//   signed OUT_WIDTH-bit PCM samples, one per DECIM input ticks.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   tick_in    single-cycle strobe; pdm_in is consumed when high
//   pdm_in     PDM bit (1 -> +1, 0 -> -1)
//   valid_out  single-cycle pulse per delivered sample
//   data_out   signed PCM sample, held between pulses
// -----------------------------------------------------------------------------
module pdm_cic_decimator #(
    parameter int DECIM     = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_in,
    input  logic                        pdm_in,
    output logic                        valid_out,
    output logic signed [OUT_WIDTH-1:0] data_out
);

    localparam int LOG2D   = $clog2(DECIM);
    localparam int ACC_W   = 2 + 3 * LOG2D;
    localparam int MAX_OUT = (2 ** (OUT_WIDTH - 1)) - 1;
    localparam int MIN_OUT = -(2 ** (OUT_WIDTH - 1));

    typedef enum logic {WARM = 1'b0, RUN = 1'b1} state_t;

    function automatic logic signed [ACC_W-1:0] shr_out(input logic signed [ACC_W-1:0] v);
        return v >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        int vi;
        vi = int'(v);
        if (vi > MAX_OUT)
            return OUT_WIDTH'(MAX_OUT);
        else if (vi < MIN_OUT)
            return OUT_WIDTH'(MIN_OUT);
        else
            return OUT_WIDTH'(vi);
    endfunction

    logic signed [ACC_W-1:0]     r_i1, r_i2, r_i3;
    logic        [LOG2D-1:0]     r_tick_cnt;
    logic signed [ACC_W-1:0]     w_x;
    logic signed [ACC_W-1:0]     w_snap;
    logic                        w_dec_evt;

    logic signed [ACC_W-1:0]     r_d1, r_d2, r_d3;
    logic signed [ACC_W-1:0]     r_c1_p1, r_c2_p2, r_c3_p3;
    logic                        r_vld_p1, r_vld_p2, r_vld_p3;

    logic        [1:0]           r_warm_cnt;
    state_t                      r_state, w_state_nxt;
    logic                        w_flag;
    logic signed [OUT_WIDTH-1:0] w_pcm;

    // +1 / -1 sign-extended to the accumulator width
    assign w_x       = {{(ACC_W-1){~pdm_in}}, 1'b1};
    assign w_dec_evt = tick_in && (r_tick_cnt == LOG2D'(DECIM - 1));
    // New i3 value (i3 + old i2) is what the decimation event captures
    assign w_snap    = r_i3 + r_i2;

    // ---- Integrators and tick counter (tick rate, modular arithmetic) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i1       <= '0;
            r_i2       <= '0;
            r_i3       <= '0;
            r_tick_cnt <= '0;
        end else if (tick_in) begin
            r_i1       <= r_i1 + w_x;
            r_i2       <= r_i2 + r_i1;
            r_i3       <= w_snap;
            r_tick_cnt <= (r_tick_cnt == LOG2D'(DECIM - 1)) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // ---- Comb stage 1: difference on the captured snapshot ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c1_p1  <= '0;
            r_d1     <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_dec_evt;
            if (w_dec_evt) begin
                r_c1_p1 <= w_snap - r_d1;
                r_d1    <= w_snap;
            end
        end
    end

    // ---- Comb stage 2 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c2_p2  <= '0;
            r_d2     <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_c2_p2 <= r_c1_p1 - r_d2;
                r_d2    <= r_c1_p1;
            end
        end
    end

    // ---- Comb stage 3 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c3_p3  <= '0;
            r_d3     <= '0;
            r_vld_p3 <= 1'b0;
        end else begin
            r_vld_p3 <= r_vld_p2;
            if (r_vld_p2) begin
                r_c3_p3 <= r_c2_p2 - r_d3;
                r_d3    <= r_c2_p2;
            end
        end
    end

    // ---- Output stage: shift, saturate, warm-up gating ----
    // Every pass produces a formatted sample; only passes in RUN are
    // published, so data_out keeps its last delivered value during warm-up.
    assign w_pcm  = sat_out(shr_out(r_c3_p3));
    assign w_flag = r_vld_p3 && (r_state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            r_warm_cnt <= '0;
        end else begin
            valid_out <= w_flag;
            if (w_flag)
                data_out <= w_pcm;
            if (r_vld_p3 && (r_state == WARM))
                r_warm_cnt <= r_warm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= WARM;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WARM:    if (r_vld_p3 && (r_warm_cnt == 2'd2)) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = WARM;
        endcase
    end

endmodule
